// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Desc     : Round-robin arbiter sharing one strobe/ack memory slave between
//            NUM_REQ requesters. Define WB_ARB_TIMEOUT_EN for the slave-ack
//            timeout and the m_err_o port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   m_strb_i,
    input  logic [NUM_REQ-1:0]   m_we_i,
    input  logic [NUM_REQ*8-1:0] m_addr_i,
    input  logic [NUM_REQ*8-1:0] m_wdata_i,
    output logic [7:0]           m_rdata_o,
    output logic [NUM_REQ-1:0]   m_ack_o,
`ifdef WB_ARB_TIMEOUT_EN
    output logic [NUM_REQ-1:0]   m_err_o,
`endif
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 s_strb_o,
    output logic                 s_we_o,
    output logic [7:0]           s_addr_o,
    output logic [7:0]           s_wdata_o,
    input  logic [7:0]           s_rdata_i,
    input  logic                 s_ack_i
);

    localparam int         C_PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_BUSY    = 2'd1;
    localparam logic [1:0] C_ST_RELEASE = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_param_check
        $error("wb_rr_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    logic [1:0]         state_q,   state_d;
    logic [C_PTR_W-1:0] ptr_q,     ptr_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic               s_strb_q,  s_strb_d;
    logic               s_we_q,    s_we_d;
    logic [7:0]         s_addr_q,  s_addr_d;
    logic [7:0]         s_wdata_q, s_wdata_d;
    logic [7:0]         m_rdata_q, m_rdata_d;
    logic [NUM_REQ-1:0] m_ack_q,   m_ack_d;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [NUM_REQ-1:0] m_err_q,   m_err_d;
    logic [7:0]         cnt_q,     cnt_d;
`endif

    logic               w_win_found;
    logic [C_PTR_W-1:0] w_win_idx;
    logic [NUM_REQ-1:0] w_win_oh;

    // First strobing requester at or after ptr, wrapping around.
    always_comb begin
        int                 idx;
        logic [C_PTR_W-1:0] cand;
        idx         = 0;
        cand        = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = C_PTR_W'(idx);
            if (!w_win_found && m_strb_i[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
        end
        w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        s_strb_d  = s_strb_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = m_ack_q;
`ifdef WB_ARB_TIMEOUT_EN
        m_err_d   = m_err_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            C_ST_IDLE: begin
                if (w_win_found) begin
                    gnt_d     = w_win_oh;
                    s_strb_d  = 1'b1;
                    s_we_d    = m_we_i[w_win_idx];
                    s_addr_d  = m_addr_i[{w_win_idx, 3'b000} +: 8];
                    s_wdata_d = m_wdata_i[{w_win_idx, 3'b000} +: 8];
                    ptr_d     = (w_win_idx == C_PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + C_PTR_W'(1);
                    state_d   = C_ST_BUSY;
`ifdef WB_ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end
            end
            // Slave-side signals stay frozen here; requester inputs are not looked at.
            C_ST_BUSY: begin
                if (s_ack_i) begin
                    s_strb_d = 1'b0;
                    m_ack_d  = gnt_q;
                    if (!s_we_q) begin
                        m_rdata_d = s_rdata_i;
                    end
                    state_d  = C_ST_RELEASE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (cnt_q == C_TIMEOUT_LAST) begin
                    s_strb_d = 1'b0;
                    m_err_d  = gnt_q;
                    state_d  = C_ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            C_ST_RELEASE: begin
                m_ack_d = '0;
                gnt_d   = '0;
`ifdef WB_ARB_TIMEOUT_EN
                m_err_d = '0;
`endif
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= C_ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            s_strb_q  <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= 8'd0;
            s_wdata_q <= 8'd0;
            m_rdata_q <= 8'd0;
            m_ack_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            m_err_q   <= '0;
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            s_strb_q  <= s_strb_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
`ifdef WB_ARB_TIMEOUT_EN
            m_err_q   <= m_err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt_o     = gnt_q;
    assign s_strb_o  = s_strb_q;
    assign s_we_o    = s_we_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;
    assign m_rdata_o = m_rdata_q;
    assign m_ack_o   = m_ack_q;
`ifdef WB_ARB_TIMEOUT_EN
    assign m_err_o   = m_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter
// Desc     : Self-checking bench for wb_rr_arbiter (NUM_REQ=4); the timeout
//            sequence runs only when WB_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   m_strb, m_we, m_ack, m_err, gnt;
    logic [N*8-1:0] m_addr, m_wdata;
    logic [7:0]     m_rdata, s_addr, s_wdata, s_rdata;
    logic           s_strb, s_we, s_ack;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .m_strb_i  (m_strb),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_wdata_i (m_wdata),
        .m_rdata_o (m_rdata),
        .m_ack_o   (m_ack),
`ifdef WB_ARB_TIMEOUT_EN
        .m_err_o   (m_err),
`endif
        .gnt_o     (gnt),
        .s_strb_o  (s_strb),
        .s_we_o    (s_we),
        .s_addr_o  (s_addr),
        .s_wdata_o (s_wdata),
        .s_rdata_i (s_rdata),
        .s_ack_i   (s_ack)
    );
`ifndef WB_ARB_TIMEOUT_EN
    assign m_err = '0;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         age   = 0;
    int         cur_lat = 2;
    bit         slave_mute = 0, force_ack = 0, rand_lat = 0;
    logic [7:0] smem [256];
    logic [7:0] ref_mem [256];
    int         ord [8];
    int         ng, nack;

    typedef struct {
        int         req;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [3:0] exp_gnt;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no event within bound, expected one (cycle %0d)", name, cyc);
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Slave model: acks cur_lat cycles after s_strb rises, random s_rdata otherwise.
    task automatic slave_step();
        bit hit;
        if (s_strb) age++; else age = 0;
        if (age == 1) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : 2;
        hit   = !slave_mute && (age == cur_lat + 1);
        s_ack = force_ack || hit;
        if (hit) begin
            if (s_we) smem[s_addr] = s_wdata;
            s_rdata = smem[s_addr];
        end else begin
            s_rdata = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        slave_step();
    endtask

    task automatic set_req(input int i, input bit strb, input bit we, input logic [7:0] a, input logic [7:0] d);
        m_strb[i]       = strb;
        m_we[i]         = we;
        m_addr[8*i +: 8]  = a;
        m_wdata[8*i +: 8] = d;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) begin
            smem[i]    = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_strb = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        force_ack = 0; slave_mute = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            n++;
            if (m_ack != 0) return;
        end
        expire("wait_ack");
    endtask

    // Records grant order; sticky requester keeps strobing until want grants are seen.
    task automatic collect(input int want, input int late_req, input int sticky);
        bit prev_s = 1'b0;
        bit late_done = 1'b0;
        int w;
        ng = 0;
        nack = 0;
        for (int c = 0; c < 80 && nack < want; c++) begin
            tick();
            if (gnt != 0) chk("gnt_onehot", $countones(gnt), 1);
            if (s_strb && !prev_s) begin
                if (ng < 8) ord[ng] = oh2i(gnt);
                ng++;
                if (late_req >= 0 && !late_done) begin
                    set_req(late_req, 1, 0, 8'h11, 8'h00);
                    late_done = 1'b1;
                end
                if (ng >= want) m_strb = '0;
            end
            if (m_ack != 0) begin
                nack++;
                w = oh2i(m_ack);
                if (w >= 0 && w != sticky) m_strb[w] = 1'b0;
            end
            prev_s = s_strb;
        end
        if (nack < want) expire("collect_acks");
    endtask

    task automatic run_table();
        int n;
        do_reset();
        init_mem();
        rst = 1'b1;
        tick();
        chk("rst_s_strb", s_strb, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_s_bus", {s_we, s_addr, s_wdata}, 0);
        chk("rst_m_rdata", m_rdata, 0);
        rst = 1'b0;
        for (int r = 0; r < 7; r++) begin
            set_req(vt[r].req, 1, vt[r].we, vt[r].addr, vt[r].wdata);
            tick();
            chk("t1_strb_latency", s_strb, 1);
            chk("t1_gnt", gnt, vt[r].exp_gnt);
            chk("t1_s_addr", s_addr, vt[r].addr);
            chk("t1_s_we", s_we, vt[r].we);
            if (vt[r].we) chk("t1_s_wdata", s_wdata, vt[r].wdata);
            wait_ack(n);
            chk("t1_ack_latency", n, 3);
            chk("t1_m_ack", m_ack, vt[r].exp_gnt);
            chk("t1_m_rdata", m_rdata, vt[r].exp_rdata);
            m_strb = '0;
            tick();
            chk("t1_ack_one_cycle", m_ack, 0);
            chk("t1_gnt_idle", gnt, 0);
        end
        force_ack = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_sack_m_ack", m_ack, 0);
            chk("idle_sack_s_strb", s_strb, 0);
        end
        force_ack = 0;
    endtask

    task automatic run_sequences();
        int n;
        int exp3 [3] = '{2, 0, 2};
        // all four at ptr=0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 8'(i), 8'h00);
        collect(4, -1, -1);
        chk("t2_num_grants", ng, 4);
        chk("t2_num_acks", nack, 4);
        for (int i = 0; i < 4; i++) chk("t2_order", ord[i], i);
        // requester 2 holds strobe, requester 0 asks once
        do_reset();
        set_req(2, 1, 0, 8'h22, 8'h00);
        collect(3, 0, 2);
        for (int i = 0; i < 3; i++) chk("t3_order", ord[i], exp3[i]);
        // reset during BUSY of a write
        do_reset();
        set_req(1, 1, 1, 8'h44, 8'h77);
        tick();
        chk("t4_busy", s_strb, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_strb = '0;
        chk("t4_s_strb", s_strb, 0);
        chk("t4_gnt", gnt, 0);
        chk("t4_m_ack", m_ack, 0);
        chk("t4_s_bus", {s_we, s_addr, s_wdata}, 0);
        chk("t4_m_rdata", m_rdata, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_no_ack", m_ack, 0);
            chk("t4_no_strb", s_strb, 0);
        end
        set_req(1, 1, 0, 8'h01, 8'h00);
        set_req(3, 1, 0, 8'h03, 8'h00);
        tick();
        chk("t4_ptr_reset", gnt, 4'b0010);
        m_strb = '0;
        wait_ack(n);
        tick();
        // address change during BUSY is ignored
        set_req(1, 1, 0, 8'h20, 8'h00);
        tick();
        chk("t5_s_addr_grant", s_addr, 8'h20);
        m_addr[15:8] = 8'h30;
        m_we[1] = 1'b1;
        for (int c = 0; c < 40 && m_ack == 0; c++) begin
            tick();
            chk("t5_s_addr_frozen", s_addr, 8'h20);
            chk("t5_s_we_frozen", s_we, 0);
        end
        chk("t5_ack", m_ack, 4'b0010);
        m_strb = '0;
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic run_timeout();
        int n;
        do_reset();
        slave_mute = 1;
        set_req(0, 1, 1, 8'h50, 8'h01);
        set_req(1, 1, 0, 8'h51, 8'h00);
        tick();
        chk("t6_gnt0", gnt, 4'b0001);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("t6_no_err_yet", m_err, 0);
            chk("t6_strb_held", s_strb, 1);
        end
        tick();
        chk("t6_m_err", m_err, 4'b0001);
        chk("t6_no_ack", m_ack, 0);
        chk("t6_s_strb_drop", s_strb, 0);
        chk("t6_rdata_kept", m_rdata, 0);
        m_strb[0] = 1'b0;
        slave_mute = 0;
        tick();
        chk("t6_err_one_cycle", m_err, 0);
        tick();
        chk("t6_next_gnt", gnt, 4'b0010);
        wait_ack(n);
        chk("t6_next_ack", m_ack, 4'b0010);
        m_strb = '0;
        tick();
    endtask
`endif

    task automatic run_random();
        bit         pend [N];
        bit         p_we [N];
        logic [7:0] p_addr [N], p_wdata [N];
        logic [N-1:0] strb_applied = '0;
        logic [7:0] exp_rd = 8'h00;
        int ph = 0, owner = -1, mptr = 0, ack_at = 0, w;
        int n_iss = 0, n_done = 0;
        bit gen = 1;
        do_reset();
        init_mem();
        rand_lat = 1;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 2400; c++) begin
            if (c == 2000) gen = 0;
            tick();
            case (ph)
                0: begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (mptr + k) % N;
                        if (w < 0 && strb_applied[i]) w = i;
                    end
                    chk("r_idle_m_ack", m_ack, 0);
                    if (w >= 0) begin
                        chk("r_grant_strb", s_strb, 1);
                        chk("r_grant_gnt", gnt, 1 << w);
                        chk("r_grant_addr", s_addr, p_addr[w]);
                        chk("r_grant_we", s_we, p_we[w]);
                        if (p_we[w]) chk("r_grant_wdata", s_wdata, p_wdata[w]);
                        owner = w;
                        mptr = (w + 1) % N;
                        ack_at = cyc + cur_lat + 1;
                        ph = 1;
                    end else begin
                        chk("r_idle_strb", s_strb, 0);
                        chk("r_idle_gnt", gnt, 0);
                    end
                end
                1: begin
                    chk("r_busy_gnt", gnt, 1 << owner);
                    if (cyc == ack_at) begin
                        chk("r_ack", m_ack, 1 << owner);
                        chk("r_ack_strb", s_strb, 0);
                        if (p_we[owner]) ref_mem[p_addr[owner]] = p_wdata[owner];
                        else exp_rd = ref_mem[p_addr[owner]];
                        pend[owner] = 0;
                        m_strb[owner] = 1'b0;
                        n_done++;
                        ph = 2;
                    end else begin
                        chk("r_busy_no_ack", m_ack, 0);
                        chk("r_busy_strb", s_strb, 1);
                        chk("r_busy_addr", s_addr, p_addr[owner]);
                    end
                end
                default: begin
                    chk("r_rel_gnt", gnt, 0);
                    chk("r_rel_ack", m_ack, 0);
                    chk("r_rel_strb", s_strb, 0);
                    owner = -1;
                    ph = 0;
                end
            endcase
            chk("r_m_rdata", m_rdata, exp_rd);
            for (int i = 0; i < N; i++) begin
                if (gen && !pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    p_we[i] = 1'($urandom);
                    p_addr[i] = 8'($urandom_range(0, 15));
                    p_wdata[i] = 8'($urandom);
                    set_req(i, 1, p_we[i], p_addr[i], p_wdata[i]);
                    n_iss++;
                end
            end
            if (ph == 1 && $urandom_range(0, 3) == 0) begin
                m_addr[8*owner +: 8] = 8'($urandom);
                m_wdata[8*owner +: 8] = 8'($urandom);
                m_we[owner] = ~m_we[owner];
            end
            if (ph == 1 && $urandom_range(0, 9) == 0) m_strb[owner] = 1'b0;
            strb_applied = m_strb;
        end
        chk("r_all_done", n_done, n_iss);
        rand_lat = 0;
    endtask

    initial begin
        vt[0] = '{1, 1'b1, 8'h10, 8'h5A, 4'b0010, 8'h00};
        vt[1] = '{1, 1'b0, 8'h10, 8'h00, 4'b0010, 8'h5A};
        vt[2] = '{3, 1'b1, 8'hFF, 8'hC3, 4'b1000, 8'h5A};
        vt[3] = '{0, 1'b0, 8'hFF, 8'h00, 4'b0001, 8'hC3};
        vt[4] = '{2, 1'b1, 8'h00, 8'h00, 4'b0100, 8'hC3};
        vt[5] = '{2, 1'b0, 8'h00, 8'h00, 4'b0100, 8'h00};
        vt[6] = '{0, 1'b0, 8'h33, 8'h00, 4'b0001, 8'h96};
        rst = 1'b1;
        m_strb = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = 8'h00;
        run_table();
        run_sequences();
`ifdef WB_ARB_TIMEOUT_EN
        run_timeout();
`endif
        run_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
